calc_nport: RTL and testbench
=============================

# calc_nport

Parametrised multi-port calculator, the next generation of the four-port `calc1` unit. It has `PORTS` independent request ports and `WIDTH`-bit operands. Each port issues one two-cycle command at a time. A single shared ALU serves all ports through a round-robin arbiter and returns a one-cycle response on the issuing port's response lines. It sits where `calc1` sits, between the request masters and the result consumers, and uses the same cmd/resp encoding.

## Interface
- `PORTS`, default 4: number of request ports, minimum 1.
- `WIDTH`, default 32: operand/result width, minimum 8. Bit 0 is the MSB.
- `SHW`, default `$clog2(WIDTH)`: width of the shift-amount field. Derived; do not override.

- `c_clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `req_cmd_in` input `4*PORTS`: port p occupies bits `[4p:4p+3]`.
- `req_data_in` input `WIDTH*PORTS`: port p occupies `[WIDTH*p : WIDTH*p+WIDTH-1]`.
- `out_resp` output `2*PORTS`: port p occupies `[2p:2p+1]`. Encoding: 0 = none, 1 = success, 2 = error (overflow, underflow or invalid command), 3 = never driven.
- `out_data` output `WIDTH*PORTS`: per-port result, sliced like `req_data_in`.

## Operation
- Commands: 0 no-op, 1 add, 2 sub, 5 shift left, 6 shift right. Any other non-zero value is invalid.
- Per-port FSM, three states:
  - IDLE: samples cmd. If non-zero, captures cmd and the data word as op1, then goes to OP2.
  - OP2: captures data as op2 unconditionally and ignores cmd, then goes to PEND.
  - PEND: waits for a grant; goes to IDLE in the grant cycle.
- A command issued while a port is in OP2 or PEND is ignored and gets no response. A master must wait for its response before issuing again.
- Arbiter:
  - Each cycle it grants at most one PEND port.
  - Search starts at the port after the last-granted port and wraps from `PORTS-1` to 0.
  - The pointer is 0 after reset, so port 0 has the highest priority first.
- ALU: operates on the granted port's op1/op2 and registers the result and response into that port's output slice.
  - Add: computed at `WIDTH+1` bits. A carry out gives resp 2, data 0. Otherwise resp 1, data = sum.
  - Sub: op2 > op1 (unsigned) gives resp 2, data 0. Otherwise resp 1, data = op1 − op2.
  - Shift left / shift right: logical shift of op1 by the low `SHW` bits of op2, zero-fill. Upper op2 bits are ignored. Always resp 1.
  - Invalid command: resp 2, data 0.
- Outputs:
  - Each port's `out_resp` is non-zero for exactly one cycle per accepted command.
  - `out_data` is valid in that same cycle and is 0 in all other cycles.

## Timing
- Cycle T: port in IDLE with cmd ≠ 0 captures op1.
- Cycle T+1: captures op2.
- From T+2: the port is PEND. With no contention it is granted in T+2.
- Cycle T+3: `out_resp`/`out_data` valid. Minimum latency is 3 cycles from cmd to response.
- Contention: the k-th port served after T+2 responds at T+3+k. The worst case is T+2+PORTS.
- A port may issue its next cmd in the cycle after its response appears. Earliest re-issue is T+4.
- Simultaneous events:
  - Several ports entering PEND in the same cycle are served in round-robin order.
  - A grant and a new op1 on different ports in the same cycle are independent.
- Reset:
  - Reset values: all `out_resp` 0, all `out_data` 0, all FSMs IDLE, pointer 0, captured operands 0.
  - On assertion, outputs clear within the same cycle (asynchronous).
  - Reset mid-command or mid-pending discards the request; no response follows after release.
  - The first cmd is sampled on the first rising edge with `reset` low.

## Test plan
- Port 0, add, op1 = 0x00000001, op2 = 0x1FFFFFFF → port 0 resp 1, data 0x20000000 exactly 3 cycles after cmd; all other ports stay 0.
- Port 1, add, 0xF0000000 + 0xF0000000 → resp 2, data 0. Port 2, sub, 5 − 7 → resp 2, data 0. Port 2, sub, 7 − 5 → resp 1, data 2.
- Port 3, shift left, op1 = 0x00000001, op2 = 0xFFFFFFE4 (low 5 bits = 4) → 0x00000010. Shift right, 0x80000000 by 31 → 0x00000001. Cmd 3 (invalid) → resp 2, data 0.
- All 4 ports issue add (i + 1, i) at the same T → responses on ports 0, 1, 2, 3 at T+3, T+4, T+5, T+6 with data 1, 3, 5, 7. Then port 0 reissues while ports 2 and 3 are also pending → service order is 2, 3, then 0 (round-robin, no starvation).
- Port 0 drives a second non-zero cmd at T+1 and T+2 → ignored; exactly one response at T+3.
- Assert `reset` at T+2 with ports 0 and 1 pending → all outputs 0 immediately; no responses for 10 cycles after release. A fresh add on port 1 then responds normally.

Source files
------------

// File: rtl/calc_nport_if.sv
// Request/response bundle for calc_nport: one 4-bit command, one data word,
// one 2-bit response and one result word per port. Port 0 occupies the most
// significant slice of every vector, port PORTS-1 the least significant one.
interface calc_nport_if #(
    parameter int PORTS = 4,
    parameter int WIDTH = 32
);
    logic [4*PORTS-1:0]     req_cmd_in;
    logic [WIDTH*PORTS-1:0] req_data_in;
    logic [2*PORTS-1:0]     out_resp;
    logic [WIDTH*PORTS-1:0] out_data;

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_resp,
        input  out_data
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_resp,
        output out_data
    );
endinterface

// File: rtl/calc_nport.sv
// calc_nport: PORTS request ports share one ALU through a round-robin arbiter.
// Each port runs IDLE -> OP2 -> PEND; a granted port gets a one-cycle response
// with its result registered into its own output slice.
module calc_nport #(
    parameter int PORTS = 4,
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic        c_clk,
    input  logic        reset,
    calc_nport_if.slave bus
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    logic [3:0]       cmd_w   [PORTS];
    logic [WIDTH-1:0] data_w  [PORTS];
    state_t           state_q [PORTS];
    state_t           state_d [PORTS];
    logic [3:0]       cmd_q   [PORTS];
    logic [WIDTH-1:0] op1_q   [PORTS];
    logic [WIDTH-1:0] op2_q   [PORTS];
    logic [1:0]       resp_q  [PORTS];
    logic [WIDTH-1:0] res_q   [PORTS];

    logic [PW-1:0]    ptr_q, ptr_d;
    logic             gnt_valid;
    logic [PW-1:0]    gnt_idx;
    logic [1:0]       alu_resp;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   alu_sum;

    // Port 0 sits in the top slice of each packed vector.
    for (genvar p = 0; p < PORTS; p++) begin : g_port
        assign cmd_w[p]  = bus.req_cmd_in[4*(PORTS-p)-1 -: 4];
        assign data_w[p] = bus.req_data_in[WIDTH*(PORTS-p)-1 -: WIDTH];
        assign bus.out_resp[2*(PORTS-p)-1 -: 2]         = resp_q[p];
        assign bus.out_data[WIDTH*(PORTS-p)-1 -: WIDTH] = res_q[p];
    end

    // Round-robin search for a pending port, starting at ptr_q.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves a value unassigned and no latch is inferred.
        int idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = (int'(ptr_q) + k) % PORTS;
            if (!gnt_valid && state_q[idx] == ST_PEND) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = (int'(gnt_idx) == PORTS-1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Per-port next-state: capture op1, capture op2, then wait for a grant.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                ST_IDLE: if (cmd_w[p] != CMD_NOP) state_d[p] = ST_OP2;
                ST_OP2:  state_d[p] = ST_PEND;
                ST_PEND: if (gnt_valid && gnt_idx == PW'(p)) state_d[p] = ST_IDLE;
                default: state_d[p] = ST_IDLE;
            endcase
        end
    end

    // Shared ALU working on the granted port's captured command and operands.
    always_comb begin
        logic [3:0]       c;
        logic [WIDTH-1:0] a, b;
        c        = cmd_q[gnt_idx];
        a        = op1_q[gnt_idx];
        b        = op2_q[gnt_idx];
        alu_sum  = {1'b0, a} + {1'b0, b};
        alu_resp = RESP_ERR;
        alu_res  = '0;
        case (c)
            CMD_ADD: if (!alu_sum[WIDTH]) begin
                alu_resp = RESP_OK;
                alu_res  = alu_sum[WIDTH-1:0];
            end
            CMD_SUB: if (b <= a) begin
                alu_resp = RESP_OK;
                alu_res  = a - b;
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_res  = a << b[SHW-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_res  = a >> b[SHW-1:0];
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_res  = '0;
            end
        endcase
    end

    // FSM state, operand capture and arbiter pointer.
    always_ff @(posedge c_clk or posedge reset) begin
        // NOTE: the per-port operand arrays are cleared on reset like any other
        // register, so an aborted request leaves no stale operands behind.
        if (reset) begin
            ptr_q <= '0;
            for (int p = 0; p < PORTS; p++) begin
                state_q[p] <= ST_IDLE;
                cmd_q[p]   <= '0;
                op1_q[p]   <= '0;
                op2_q[p]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            ptr_q <= ptr_d;
            for (int p = 0; p < PORTS; p++) begin
                state_q[p] <= state_d[p];
                if (state_q[p] == ST_IDLE && cmd_w[p] != CMD_NOP) begin
                    cmd_q[p] <= cmd_w[p];
                    op1_q[p] <= data_w[p];
                end
                if (state_q[p] == ST_OP2) begin
                    op2_q[p] <= data_w[p];
                end
            end
        end
    end

    // One-cycle response: only the granted port's slice is non-zero.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < PORTS; p++) begin
                resp_q[p] <= RESP_NONE;
                res_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (gnt_valid && gnt_idx == PW'(p)) begin
                    resp_q[p] <= alu_resp;
                    res_q[p]  <= alu_res;
                end else begin
                    resp_q[p] <= RESP_NONE;
                    res_q[p]  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_calc_nport.sv
// Scoreboard bench for calc_nport: directed stimulus pushes hand-computed
// expected responses (port, resp, data, cycle) into a queue; a monitor on the
// falling edge pops and compares every response the DUT presents.
module tb_calc_nport;
    localparam int PORTS = 4;
    localparam int WIDTH = 32;

    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] SHL = 4'd5;
    localparam logic [3:0] SHR = 4'd6;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    always #5 c_clk = ~c_clk;

    calc_nport_if #(.PORTS(PORTS), .WIDTH(WIDTH)) bus ();

    calc_nport #(.PORTS(PORTS), .WIDTH(WIDTH)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int               port;
        logic [1:0]       resp;
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    typedef struct {
        int               port;
        logic [3:0]       cmd;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       resp;
        logic [WIDTH-1:0] data;
    } vec_t;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    logic [3:0]       st_cmd [PORTS];
    logic [WIDTH-1:0] st_a   [PORTS];
    logic [WIDTH-1:0] st_b   [PORTS];

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [1:0] get_resp(input int p);
        return bus.out_resp[2*(PORTS-p)-1 -: 2];
    endfunction

    function automatic logic [WIDTH-1:0] get_data(input int p);
        return bus.out_data[WIDTH*(PORTS-p)-1 -: WIDTH];
    endfunction

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] c, input logic [WIDTH-1:0] d);
        bus.req_cmd_in[4*(PORTS-p)-1 -: 4]          = c;
        bus.req_data_in[WIDTH*(PORTS-p)-1 -: WIDTH] = d;
    endtask

    task automatic push(input int p, input logic [1:0] r, input logic [WIDTH-1:0] d, input int at);
        exp_t e;
        e.port = p; e.resp = r; e.data = d; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic stage(input int p, input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        st_cmd[p] = c; st_a[p] = a; st_b[p] = b;
    endtask

    // Issues the staged command on every port in mask during the same cycles.
    task automatic issue_mask(input logic [PORTS-1:0] mask);
        for (int p = 0; p < PORTS; p++) if (mask[p]) set_port(p, st_cmd[p], st_a[p]);
        tick();
        for (int p = 0; p < PORTS; p++) if (mask[p]) set_port(p, 4'd0, st_b[p]);
        tick();
        for (int p = 0; p < PORTS; p++) if (mask[p]) set_port(p, 4'd0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
        check("drain_queue", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    // Monitor: every non-zero response must match the head of the queue.
    always @(negedge c_clk) begin
        exp_t e;
        for (int p = 0; p < PORTS; p++) begin
            if (get_resp(p) != 2'd0) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_resp_p%0d", p), get_resp(p), 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("resp_port_p%0d", p), p, e.port);
                    check($sformatf("resp_code_p%0d", p), get_resp(p), e.resp);
                    check($sformatf("resp_data_p%0d", p), get_data(p), e.data);
                    check($sformatf("resp_cycle_p%0d", p), cyc, e.cyc);
                end
            end else begin
                check($sformatf("idle_data_p%0d", p), get_data(p), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    vec_t vecs[12] = '{
        '{0, ADD,  32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000},
        '{1, ADD,  32'hF000_0000, 32'hF000_0000, 2'd2, 32'h0000_0000},
        '{1, ADD,  32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF},
        '{1, ADD,  32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000},
        '{2, SUB,  32'h0000_0005, 32'h0000_0007, 2'd2, 32'h0000_0000},
        '{2, SUB,  32'h0000_0007, 32'h0000_0005, 2'd1, 32'h0000_0002},
        '{2, SUB,  32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000},
        '{3, SHL,  32'h0000_0001, 32'hFFFF_FFE4, 2'd1, 32'h0000_0010},
        '{3, SHR,  32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001},
        '{3, SHL,  32'h0000_0001, 32'h0000_0020, 2'd1, 32'h0000_0001},
        '{3, 4'd3, 32'h0000_1234, 32'h0000_0001, 2'd2, 32'h0000_0000},
        '{3, 4'd15, 32'h0000_00FF, 32'h0000_0002, 2'd2, 32'h0000_0000}
    };

    initial begin
        int t;
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
        for (int p = 0; p < PORTS; p++) stage(p, 4'd0, '0, '0);

        // Reset values.
        #2 reset = 1'b1;
        #1;
        check("reset_resp", bus.out_resp, 0);
        check("reset_data_p0", get_data(0), 0);
        repeat (3) @(posedge c_clk);
        #1 reset = 1'b0;
        tick();

        // Single-port operations, one at a time; last one on port 3 so the
        // pointer wraps back to port 0.
        foreach (vecs[i]) begin
            stage(vecs[i].port, vecs[i].cmd, vecs[i].a, vecs[i].b);
            push(vecs[i].port, vecs[i].resp, vecs[i].data, cyc + 3);
            issue_mask(PORTS'(1) << vecs[i].port);
            drain();
        end

        // All four ports at once, then port 0 reissues right after its response.
        t = cyc;
        for (int p = 0; p < PORTS; p++) stage(p, ADD, WIDTH'(p + 1), WIDTH'(p));
        push(0, 2'd1, 32'd1, t + 3);
        push(1, 2'd1, 32'd3, t + 4);
        push(2, 2'd1, 32'd5, t + 5);
        push(3, 2'd1, 32'd7, t + 6);
        push(0, 2'd1, 32'd30, t + 7);
        issue_mask(4'b1111);
        tick();
        tick();
        stage(0, ADD, 32'd10, 32'd20);
        issue_mask(4'b0001);
        drain();

        // Port 1 moves the pointer to 2; then ports 0, 2, 3 contend.
        stage(1, ADD, 32'h100, 32'h1);
        push(1, 2'd1, 32'h101, cyc + 3);
        issue_mask(4'b0010);
        drain();
        t = cyc;
        stage(0, SUB, 32'd9, 32'd4);
        stage(2, SHL, 32'd3, 32'd2);
        stage(3, SHR, 32'h40, 32'd3);
        push(2, 2'd1, 32'd12, t + 3);
        push(3, 2'd1, 32'd8, t + 4);
        push(0, 2'd1, 32'd5, t + 5);
        issue_mask(4'b1101);
        drain();

        // Command held non-zero during OP2 and PEND: only one response.
        t = cyc;
        push(0, 2'd1, 32'd5, t + 3);
        set_port(0, ADD, 32'd2);
        tick();
        set_port(0, SUB, 32'd3);
        tick();
        set_port(0, ADD, 32'hFF);
        tick();
        set_port(0, 4'd0, '0);
        drain();

        // Reset with a response on the bus and ports 0, 1 pending.
        set_port(2, ADD, 32'd1);
        tick();
        set_port(2, 4'd0, 32'd1);
        set_port(0, ADD, 32'd3);
        set_port(1, ADD, 32'd4);
        tick();
        set_port(2, 4'd0, '0);
        set_port(0, 4'd0, 32'd5);
        set_port(1, 4'd0, 32'd6);
        tick();
        set_port(0, 4'd0, '0);
        set_port(1, 4'd0, '0);
        check("pre_reset_resp_p2", get_resp(2), 1);
        check("pre_reset_data_p2", get_data(2), 2);
        #1 reset = 1'b1;
        #1;
        for (int p = 0; p < PORTS; p++) begin
            check($sformatf("async_reset_resp_p%0d", p), get_resp(p), 0);
            check($sformatf("async_reset_data_p%0d", p), get_data(p), 0);
        end
        repeat (2) @(posedge c_clk);
        #1 reset = 1'b0;
        repeat (10) tick();
        check("post_reset_silence", exp_q.size(), 0);

        // Fresh requests after reset: pointer is back at 0, so port 1 before 3.
        t = cyc;
        stage(1, ADD, 32'h11, 32'h22);
        stage(3, ADD, 32'hAB, 32'h0);
        push(1, 2'd1, 32'h33, t + 3);
        push(3, 2'd1, 32'hAB, t + 4);
        issue_mask(4'b1010);
        drain();

        repeat (5) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
